// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the 3-stage 16-bit pipe.
//   opcode_e      : IE opcode encoding
//   writes_rd()   : 1 when an opcode produces a register-file write
//   rd_in_range() : 1 when a destination index names an architectural register
package pipe_pkg;

  localparam int NUM_REGS_DEF = 4;
  localparam int RD_W         = 4;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_AND = 4'h3,
    OP_OR  = 4'h4,
    OP_XOR = 4'h5,
    OP_SHL = 4'h6,
    OP_LI  = 4'h7,
    OP_LD  = 4'h8,
    OP_ST  = 4'h9,
    OP_BR  = 4'hA
  } opcode_e;

  function automatic logic writes_rd(input logic [3:0] op);
    return !((op == OP_NOP) || (op == OP_ST) || (op == OP_BR));
  endfunction

  function automatic logic rd_in_range(input logic [RD_W-1:0] rd, input int n);
    return ({28'd0, rd} < $unsigned(n));
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: DEPTH-entry circular buffer of {rd, data} write-back results.
//   push_i/push_rd_i/push_data_i : enqueue (caller guarantees not full)
//   pop_i                        : dequeue head (caller guarantees not empty)
//   count_o                      : number of valid entries
//   head_rd_o/head_data_o        : oldest entry
//   ent_*_o[a]                   : entry at age a from the head (a=0 oldest),
//                                  used for the pending mask and forwarding
module wb_fifo
  import pipe_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [RD_W-1:0]            push_rd_i,
  input  logic [DATA_W-1:0]          push_data_i,
  input  logic                       pop_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [RD_W-1:0]            head_rd_o,
  output logic [DATA_W-1:0]          head_data_o,
  output logic                       ent_valid_o [DEPTH],
  output logic [RD_W-1:0]            ent_rd_o    [DEPTH],
  output logic [DATA_W-1:0]          ent_data_o  [DEPTH]
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [RD_W-1:0]   rd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: every read is qualified by count.
  always_ff @(posedge clk) begin
    if (push_i) begin
      rd_mem[wr_ptr_q]   <= push_rd_i;
      data_mem[wr_ptr_q] <= push_data_i;
    end
  end

  always_comb begin
    for (int a = 0; a < DEPTH; a++) begin
      ent_valid_o[a] = CW'(a) < count_q;
      ent_rd_o[a]    = rd_mem[rd_ptr_q + PW'(a)];
      ent_data_o[a]  = data_mem[rd_ptr_q + PW'(a)];
    end
  end

  assign count_o     = count_q;
  assign head_rd_o   = rd_mem[rd_ptr_q];
  assign head_data_o = data_mem[rd_ptr_q];

endmodule

// File: rtl/wb_stage.sv
// wb_stage: write-back stage. Buffers IE results, merges load returns
// (which take priority), and drives the registered register-file write port.
//   ie_*        : IE result input with ready handshake
//   mem_*       : load return, always accepted
//   rf_*        : registered register-file write port
//   pending     : registers with a write still in flight (FIFO or rf_*)
//   fwd*        : two forwarding lookups, youngest in-flight value wins
//   err_bad_rd  : sticky out-of-range destination flag
module wb_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 4,
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ie_valid,
  input  logic [3:0]          ie_opcode,
  input  logic [3:0]          ie_rd,
  input  logic [DATA_W-1:0]   ie_result,
  output logic                ie_ready,
  input  logic                mem_valid,
  input  logic [3:0]          mem_rd,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                rf_we,
  output logic [3:0]          rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [NUM_REGS-1:0] pending,
  input  logic [3:0]          fwd_rs1,
  output logic                fwd1_hit,
  output logic [DATA_W-1:0]   fwd1_data,
  input  logic [3:0]          fwd_rs2,
  output logic                fwd2_hit,
  output logic [DATA_W-1:0]   fwd2_data,
  output logic                err_bad_rd
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]     count;
  logic [3:0]        head_rd;
  logic [DATA_W-1:0] head_data;
  logic              ent_valid [DEPTH];
  logic [3:0]        ent_rd    [DEPTH];
  logic [DATA_W-1:0] ent_data  [DEPTH];

  logic              ie_take, push, ie_bad, mem_wr, mem_bad, pop;
  logic              rf_we_q, rf_we_d, err_q, err_d;
  logic [3:0]        rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  // Ready depends only on registered count: a full FIFO refuses even when popping.
  assign ie_ready = (count != CW'(DEPTH));

  always_comb begin
    ie_take = ie_valid && ie_ready && writes_rd(ie_opcode);
    push    = ie_take && rd_in_range(ie_rd, NUM_REGS);
    ie_bad  = ie_take && !rd_in_range(ie_rd, NUM_REGS);
    mem_wr  = mem_valid && rd_in_range(mem_rd, NUM_REGS);
    mem_bad = mem_valid && !rd_in_range(mem_rd, NUM_REGS);
    // A dropped load does not occupy the write port, so the head may drain.
    pop     = !mem_wr && (count != '0);
    err_d   = err_q || ie_bad || mem_bad;

    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (mem_wr) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = mem_rd;
      rf_wdata_d = mem_data;
    end else if (pop) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = head_rd;
      rf_wdata_d = head_data;
    end
  end

  wb_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_rd_i   (ie_rd),
    .push_data_i (ie_result),
    .pop_i       (pop),
    .count_o     (count),
    .head_rd_o   (head_rd),
    .head_data_o (head_data),
    .ent_valid_o (ent_valid),
    .ent_rd_o    (ent_rd),
    .ent_data_o  (ent_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      err_q      <= err_d;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign err_bad_rd = err_q;

  always_comb begin
    pending = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (rf_we_q && (rf_waddr_q == 4'(r))) pending[r] = 1'b1;
      for (int a = 0; a < DEPTH; a++) begin
        if (ent_valid[a] && (ent_rd[a] == 4'(r))) pending[r] = 1'b1;
      end
    end
  end

  // rf_* is older than anything in the FIFO; scanning oldest-to-youngest
  // lets the last match (youngest) win.
  function automatic logic [DATA_W:0] fwd_lookup(input logic [3:0] idx);
    logic              hit;
    logic [DATA_W-1:0] data;
    hit  = 1'b0;
    data = '0;
    if (rd_in_range(idx, NUM_REGS)) begin
      if (rf_we_q && (rf_waddr_q == idx)) begin
        hit  = 1'b1;
        data = rf_wdata_q;
      end
      for (int a = 0; a < DEPTH; a++) begin
        if (ent_valid[a] && (ent_rd[a] == idx)) begin
          hit  = 1'b1;
          data = ent_data[a];
        end
      end
    end
    return {hit, data};
  endfunction

  always_comb begin
    {fwd1_hit, fwd1_data} = fwd_lookup(fwd_rs1);
    {fwd2_hit, fwd2_data} = fwd_lookup(fwd_rs2);
  end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
  import pipe_pkg::*;

  logic        clk, rst;
  logic        ie_valid, ie_ready, mem_valid, rf_we;
  logic [3:0]  ie_opcode, ie_rd, mem_rd, rf_waddr, fwd_rs1, fwd_rs2, pending;
  logic [15:0] ie_result, mem_data, rf_wdata, fwd1_data, fwd2_data;
  logic        fwd1_hit, fwd2_hit, err_bad_rd;

  int n_tests = 0;
  int n_fail  = 0;

  wb_stage #(.DATA_W(16), .DEPTH(4), .NUM_REGS(4)) dut (
    .clk(clk), .rst(rst),
    .ie_valid(ie_valid), .ie_opcode(ie_opcode), .ie_rd(ie_rd), .ie_result(ie_result),
    .ie_ready(ie_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pending(pending),
    .fwd_rs1(fwd_rs1), .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
    .fwd_rs2(fwd_rs2), .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
    .err_bad_rd(err_bad_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #3;
  endtask

  task automatic ie_drive(input logic v, input logic [3:0] op, input logic [3:0] rd,
                          input logic [15:0] res);
    ie_valid  = v;
    ie_opcode = op;
    ie_rd     = rd;
    ie_result = res;
  endtask

  task automatic mem_drive(input logic v, input logic [3:0] rd, input logic [15:0] d);
    mem_valid = v;
    mem_rd    = rd;
    mem_data  = d;
  endtask

  task automatic rf_expect(input string tag, input logic we, input logic [3:0] a,
                           input logic [15:0] d);
    check({tag, "_we"}, rf_we, we);
    if (we) begin
      check({tag, "_addr"}, rf_waddr, a);
      check({tag, "_data"}, rf_wdata, d);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [3:0]  t3_rd   [5];
  logic [15:0] t3_data [5];

  initial begin
    t3_rd   = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1};
    t3_data = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505};

    rst = 1'b0;
    ie_drive(1'b0, OP_NOP, 4'd0, 16'h0);
    mem_drive(1'b0, 4'd0, 16'h0);
    fwd_rs1 = 4'd0;
    fwd_rs2 = 4'd0;
    settle;
    check("rst_we", rf_we, 1'b0);
    check("rst_waddr", rf_waddr, 4'd0);
    check("rst_wdata", rf_wdata, 16'h0);
    check("rst_err", err_bad_rd, 1'b0);
    check("rst_pending", pending, 4'b0000);
    check("rst_ready", ie_ready, 1'b1);
    check("rst_fwd1", fwd1_hit, 1'b0);
    next_cycle;
    next_cycle;
    rst = 1'b1;

    // 1: single ADD, two-cycle latency
    ie_drive(1'b1, OP_ADD, 4'd2, 16'h1234);
    settle;
    check("t1_ready", ie_ready, 1'b1);
    next_cycle;
    ie_drive(1'b0, OP_NOP, 4'd0, 16'h0);
    settle;
    check("t1_pend_n1", pending, 4'b0100);
    check("t1_we_n1", rf_we, 1'b0);
    next_cycle;
    settle;
    rf_expect("t1_n2", 1'b1, 4'd2, 16'h1234);
    check("t1_pend_n2", pending, 4'b0100);
    next_cycle;
    settle;
    check("t1_we_n3", rf_we, 1'b0);
    check("t1_pend_n3", pending, 4'b0000);
    check("t1_hold_data", rf_wdata, 16'h1234);

    // 2: load return beats a ready FIFO head
    next_cycle;
    ie_drive(1'b1, OP_SUB, 4'd3, 16'h0005);
    next_cycle;
    ie_drive(1'b0, OP_NOP, 4'd0, 16'h0);
    mem_drive(1'b1, 4'd1, 16'hBEEF);
    settle;
    check("t2_pend_a1", pending, 4'b1000);
    check("t2_we_a1", rf_we, 1'b0);
    next_cycle;
    mem_drive(1'b0, 4'd0, 16'h0);
    settle;
    rf_expect("t2_mem", 1'b1, 4'd1, 16'hBEEF);
    check("t2_pend_a2", pending, 4'b1010);
    next_cycle;
    settle;
    rf_expect("t2_head", 1'b1, 4'd3, 16'h0005);
    check("t2_pend_a3", pending, 4'b1000);
    next_cycle;
    settle;
    check("t2_we_a4", rf_we, 1'b0);

    // 3: fill under sustained loads, then drain with wrap-around
    next_cycle;
    mem_drive(1'b1, 4'd0, 16'hA000);
    for (int i = 0; i < 4; i++) begin
      ie_drive(1'b1, OP_ADD, t3_rd[i], t3_data[i]);
      settle;
      check($sformatf("t3_ready_%0d", i), ie_ready, 1'b1);
      next_cycle;
    end
    ie_drive(1'b1, OP_ADD, t3_rd[4], t3_data[4]);
    settle;
    check("t3_full", ie_ready, 1'b0);
    check("t3_pend_full", pending, 4'b1111);
    rf_expect("t3_memwr", 1'b1, 4'd0, 16'hA000);
    next_cycle;
    mem_drive(1'b0, 4'd0, 16'h0);
    settle;
    check("t3_full_popping", ie_ready, 1'b0);
    next_cycle;
    settle;
    check("t3_ready_back", ie_ready, 1'b1);
    rf_expect("t3_drain_0", 1'b1, t3_rd[0], t3_data[0]);
    next_cycle;
    ie_drive(1'b0, OP_NOP, 4'd0, 16'h0);
    for (int i = 1; i < 5; i++) begin
      settle;
      rf_expect($sformatf("t3_drain_%0d", i), 1'b1, t3_rd[i], t3_data[i]);
      next_cycle;
    end
    settle;
    check("t3_empty_we", rf_we, 1'b0);
    check("t3_empty_pend", pending, 4'b0000);

    // 4: forwarding, youngest wins
    next_cycle;
    mem_drive(1'b1, 4'd3, 16'h7777);
    ie_drive(1'b1, OP_ADD, 4'd1, 16'h0011);
    next_cycle;
    ie_drive(1'b1, OP_ADD, 4'd1, 16'h0022);
    next_cycle;
    ie_drive(1'b0, OP_NOP, 4'd0, 16'h0);
    fwd_rs1 = 4'd1;
    fwd_rs2 = 4'd0;
    settle;
    check("t4_f1_hit", fwd1_hit, 1'b1);
    check("t4_f1_data", fwd1_data, 16'h0022);
    check("t4_f2_miss", fwd2_hit, 1'b0);
    check("t4_f2_zero", fwd2_data, 16'h0);
    fwd_rs2 = 4'd3;
    #1;
    check("t4_f2_rf_hit", fwd2_hit, 1'b1);
    check("t4_f2_rf_data", fwd2_data, 16'h7777);
    next_cycle;
    mem_drive(1'b0, 4'd0, 16'h0);
    next_cycle;
    fwd_rs2 = 4'd9;
    settle;
    rf_expect("t4_rf_old", 1'b1, 4'd1, 16'h0011);
    check("t4_fifo_over_rf", fwd1_data, 16'h0022);
    check("t4_idx9_miss", fwd2_hit, 1'b0);
    next_cycle;
    settle;
    check("t4_rf_only_hit", fwd1_hit, 1'b1);
    check("t4_rf_only_data", fwd1_data, 16'h0022);
    next_cycle;
    settle;
    check("t4_gone_hit", fwd1_hit, 1'b0);
    check("t4_gone_data", fwd1_data, 16'h0);

    // 5: discarded results
    ie_drive(1'b1, OP_NOP, 4'd2, 16'hDEAD);
    next_cycle;
    ie_drive(1'b1, OP_ADD, 4'd9, 16'hBEEF);
    settle;
    check("t5_err_before", err_bad_rd, 1'b0);
    check("t5_nop_pend", pending, 4'b0000);
    next_cycle;
    ie_drive(1'b0, OP_NOP, 4'd0, 16'h0);
    settle;
    check("t5_err_set", err_bad_rd, 1'b1);
    check("t5_pend", pending, 4'b0000);
    check("t5_we_d2", rf_we, 1'b0);
    next_cycle;
    settle;
    check("t5_we_d3", rf_we, 1'b0);
    check("t5_err_sticky", err_bad_rd, 1'b1);

    // 6: reset with buffered entries
    next_cycle;
    mem_drive(1'b1, 4'd3, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      ie_drive(1'b1, OP_ADD, 4'(i), 16'h00A0 + 16'(i));
      next_cycle;
    end
    ie_drive(1'b0, OP_NOP, 4'd0, 16'h0);
    settle;
    check("t6_pend_pre", pending, 4'b1111);
    rst = 1'b0;
    mem_drive(1'b0, 4'd0, 16'h0);
    #1;
    check("t6_rst_we", rf_we, 1'b0);
    check("t6_rst_pend", pending, 4'b0000);
    check("t6_rst_ready", ie_ready, 1'b1);
    check("t6_rst_err", err_bad_rd, 1'b0);
    check("t6_rst_wdata", rf_wdata, 16'h0);
    next_cycle;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle;
      check($sformatf("t6_stale_we_%0d", i), rf_we, 1'b0);
      check($sformatf("t6_stale_pend_%0d", i), pending, 4'b0000);
      next_cycle;
    end

    // bad load destination: dropped, flags error
    mem_drive(1'b1, 4'd8, 16'h1111);
    next_cycle;
    mem_drive(1'b0, 4'd0, 16'h0);
    settle;
    check("t7_mem_bad_err", err_bad_rd, 1'b1);
    check("t7_mem_bad_we", rf_we, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
